// File: rtl/kgp_pkg.sv
// Shared definitions for the KGP-RISC multicycle control unit: opcodes, FSM
// states, writeback select codes, branch conditions and branch offset decode.
package kgp_pkg;

    // Opcode field IR[31:29]
    localparam logic [2:0] OP_ALU  = 3'b000;
    localparam logic [2:0] OP_ALUI = 3'b001;
    localparam logic [2:0] OP_LD   = 3'b010;
    localparam logic [2:0] OP_ST   = 3'b011;
    localparam logic [2:0] OP_BR   = 3'b100;
    localparam logic [2:0] OP_BAL  = 3'b101;
    localparam logic [2:0] OP_JR   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    // Control FSM states
    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StHalt
    } state_e;

    // Register-file writeback source select
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    // Conditional branch condition codes, IR[4:0]; any other value never branches
    localparam logic [4:0] COND_ALWAYS = 5'd0;
    localparam logic [4:0] COND_ZERO   = 5'd1;
    localparam logic [4:0] COND_SIGN   = 5'd2;
    localparam logic [4:0] COND_CARRY  = 5'd3;

    // ALU function used for address and immediate arithmetic
    localparam logic [4:0] ALU_ADD = 5'd0;

    // Word-aligned branch byte offset. The conditional branch keeps its
    // condition in IR[4:0], so its immediate is the 11-bit field IR[15:5];
    // branch-and-link has no condition and uses the full IR[15:0].
    function automatic logic [31:0] branch_offset(input logic [2:0]  op,
                                                  input logic [15:0] imm);
        if (op == OP_BR) begin
            return {{19{imm[15]}}, imm[15:5], 2'b00};
        end
        return {{14{imm[15]}}, imm[15:0], 2'b00};
    endfunction

endpackage

// File: rtl/kgp_branch_unit.sv
// Combinational branch resolution: decides whether a control-transfer
// instruction is taken and where it goes, from the opcode, immediate, PC,
// ALU flags and the jump-register operand.
module kgp_branch_unit
    import kgp_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [15:0] imm_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] read1_i,
    input  logic        flag_zero_i,
    input  logic        flag_sign_i,
    input  logic        flag_carry_i,
    output logic        taken_o,
    output logic [31:0] target_o,
    output logic [31:0] pc_plus4_o
);

    logic [31:0] br_target;

    // PC arithmetic wraps modulo 2^32
    assign pc_plus4_o = pc_i + 32'd4;
    assign br_target  = pc_plus4_o + branch_offset(op_i, imm_i);

    // Resolve taken/target per opcode; non-transfer opcodes are never taken
    always_comb begin
        taken_o  = 1'b0;
        target_o = br_target;
        case (op_i)
            OP_BR: begin
                case (imm_i[4:0])
                    COND_ALWAYS: taken_o = 1'b1;
                    COND_ZERO:   taken_o = flag_zero_i;
                    COND_SIGN:   taken_o = flag_sign_i;
                    COND_CARRY:  taken_o = flag_carry_i;
                    default:     taken_o = 1'b0;
                endcase
            end
            OP_BAL: begin
                taken_o = 1'b1;
            end
            OP_JR: begin
                taken_o  = 1'b1;
                target_o = read1_i;
            end
            default: begin
                taken_o  = 1'b0;
                target_o = pc_plus4_o;
            end
        endcase
    end

endmodule

// File: rtl/kgp_control_fsm.sv
// Multicycle control unit for the KGP-RISC core. Sequences FETCH, DECODE,
// EXEC, MEM and WB, owns the PC and the instruction register, and drives the
// register-file, ALU and memory controls. All control outputs are registered
// and describe the state currently held in state_q.
module kgp_control_fsm
    import kgp_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned MEM_WAIT_MAX = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic        imem_req,
    output logic [31:0] pc,
    input  logic        dmem_ready,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic [31:0] read1,
    input  logic        flag_zero,
    input  logic        flag_sign,
    input  logic        flag_carry,
    output logic [4:0]  reg1,
    output logic [4:0]  reg2,
    output logic        reg_write,
    output logic        reg_dest,
    output logic [4:0]  alu_op,
    output logic        alu_src_imm,
    output logic [1:0]  wb_sel,
    output logic        halted
);

    localparam int unsigned     CntW     = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CntW-1:0] WaitLast = CntW'(MEM_WAIT_MAX - 1);

    state_e          state_q;
    logic [31:0]     pc_q;
    logic [31:0]     ir_q;
    logic [CntW-1:0] wait_cnt_q;

    logic            imem_req_q;
    logic            dmem_req_q;
    logic            dmem_we_q;
    logic            reg_write_q;
    logic            reg_dest_q;
    logic [4:0]      alu_op_q;
    logic            alu_src_imm_q;
    logic [1:0]      wb_sel_q;
    logic            halted_q;

    logic [2:0]      op;
    logic            br_taken;
    logic [31:0]     br_target;
    logic [31:0]     pc_plus4;
    logic            unused_ir_bits;

    assign op             = ir_q[31:29];
    assign unused_ir_bits = ^ir_q[28:26];

    kgp_branch_unit u_branch (
        .op_i         (op),
        .imm_i        (ir_q[15:0]),
        .pc_i         (pc_q),
        .read1_i      (read1),
        .flag_zero_i  (flag_zero),
        .flag_sign_i  (flag_sign),
        .flag_carry_i (flag_carry),
        .taken_o      (br_taken),
        .target_o     (br_target),
        .pc_plus4_o   (pc_plus4)
    );

    // State, PC, IR and registered outputs; outputs are loaded for the state being entered
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q       <= StFetch;
            pc_q          <= RESET_PC;
            ir_q          <= '0;
            wait_cnt_q    <= '0;
            imem_req_q    <= 1'b0;
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            reg_write_q   <= 1'b0;
            reg_dest_q    <= 1'b0;
            alu_op_q      <= '0;
            alu_src_imm_q <= 1'b0;
            wb_sel_q      <= WB_ALU;
            halted_q      <= 1'b0;
        end else begin
            imem_req_q    <= 1'b0;
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            reg_write_q   <= 1'b0;
            reg_dest_q    <= 1'b0;
            alu_op_q      <= '0;
            alu_src_imm_q <= 1'b0;
            wb_sel_q      <= WB_ALU;

            unique case (state_q)
                StFetch: begin
                    // The request is low for one cycle after reset, so only
                    // accept a response to a request actually presented.
                    if (imem_req_q && imem_ready) begin
                        ir_q    <= imem_rdata;
                        state_q <= StDecode;
                    end else begin
                        imem_req_q <= 1'b1;
                    end
                end

                StDecode: begin
                    if (op == OP_HALT) begin
                        state_q  <= StHalt;
                        halted_q <= 1'b1;
                    end else begin
                        state_q       <= StExec;
                        alu_op_q      <= (op == OP_ALU) ? ir_q[4:0] : ALU_ADD;
                        alu_src_imm_q <= (op == OP_ALUI) || (op == OP_LD) || (op == OP_ST);
                    end
                end

                StExec: begin
                    unique case (op)
                        OP_ALU, OP_ALUI: begin
                            state_q     <= StWb;
                            reg_write_q <= 1'b1;
                            reg_dest_q  <= 1'b0;
                            wb_sel_q    <= WB_ALU;
                        end
                        OP_LD, OP_ST: begin
                            state_q    <= StMem;
                            wait_cnt_q <= '0;
                            dmem_req_q <= 1'b1;
                            dmem_we_q  <= (op == OP_ST);
                        end
                        OP_BR, OP_JR: begin
                            pc_q       <= br_taken ? br_target : pc_plus4;
                            state_q    <= StFetch;
                            imem_req_q <= 1'b1;
                        end
                        OP_BAL: begin
                            state_q    <= StWb;
                            reg_dest_q <= 1'b1;
                            wb_sel_q   <= WB_PC4;
                        end
                        default: begin
                            // HALT is diverted in DECODE and cannot get here
                            state_q  <= StHalt;
                            halted_q <= 1'b1;
                        end
                    endcase
                end

                StMem: begin
                    if (dmem_ready) begin
                        wait_cnt_q <= '0;
                        if (op == OP_LD) begin
                            state_q     <= StWb;
                            reg_write_q <= 1'b1;
                            reg_dest_q  <= 1'b1;
                            wb_sel_q    <= WB_MEM;
                        end else begin
                            pc_q       <= pc_plus4;
                            state_q    <= StFetch;
                            imem_req_q <= 1'b1;
                        end
                    end else if (wait_cnt_q == WaitLast) begin
                        // Data memory never answered: give up and halt
                        state_q  <= StHalt;
                        halted_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CntW'(1);
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= dmem_we_q;
                    end
                end

                StWb: begin
                    // Branch-and-link writes PC+4 to r31 and jumps to its target
                    pc_q       <= (op == OP_BAL) ? br_target : pc_plus4;
                    state_q    <= StFetch;
                    imem_req_q <= 1'b1;
                end

                StHalt: begin
                    halted_q <= 1'b1;
                end

                default: begin
                    state_q  <= StHalt;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign pc          = pc_q;
    assign dmem_req    = dmem_req_q;
    assign dmem_we     = dmem_we_q;
    assign reg_write   = reg_write_q;
    assign reg_dest    = reg_dest_q;
    assign alu_op      = alu_op_q;
    assign alu_src_imm = alu_src_imm_q;
    assign wb_sel      = wb_sel_q;
    assign halted      = halted_q;

    // Register addresses follow IR; parked at zero while halted
    assign reg1 = (state_q == StHalt) ? 5'd0 : ir_q[25:21];
    assign reg2 = (state_q == StHalt) ? 5'd0 : ir_q[20:16];

endmodule

// File: tb/tb_kgp_control_fsm.sv
// Self-checking bench for kgp_control_fsm: table of single-instruction
// vectors plus hand-written reset, memory-timeout and HALT sequences.
module tb_kgp_control_fsm;
    import kgp_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        imem_req;
    logic [31:0] pc;
    logic        dmem_ready;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] read1;
    logic        flag_zero, flag_sign, flag_carry;
    logic [4:0]  reg1, reg2, alu_op;
    logic        reg_write, reg_dest, alu_src_imm, halted;
    logic [1:0]  wb_sel;

    always #5 clock = ~clock;

    kgp_control_fsm #(
        .RESET_PC     (32'h0000_0000),
        .MEM_WAIT_MAX (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .imem_req    (imem_req),
        .pc          (pc),
        .dmem_ready  (dmem_ready),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .read1       (read1),
        .flag_zero   (flag_zero),
        .flag_sign   (flag_sign),
        .flag_carry  (flag_carry),
        .reg1        (reg1),
        .reg2        (reg2),
        .reg_write   (reg_write),
        .reg_dest    (reg_dest),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .wb_sel      (wb_sel),
        .halted      (halted)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Observations of one instruction run
    int          r_cycles, r_ctl_cnt, r_mem;
    logic [4:0]  r_reg1, r_reg2, r_alu;
    logic        r_imm, r_rw, r_rd, r_we, r_halted;
    logic [1:0]  r_wb;
    logic [31:0] r_pc;

    typedef struct {
        logic [31:0] start_pc;
        logic [31:0] instr;
        logic [31:0] rd1;
        logic [2:0]  flags;   // {zero, sign, carry}
        int          fw;      // cycles imem_ready held low
        int          md;      // dmem_ready delay
        int          cyc;
        logic [4:0]  e_reg1;
        logic [4:0]  e_reg2;
        logic [4:0]  e_alu;
        logic        e_imm;
        logic        e_rw;
        logic        e_rd;
        logic [1:0]  e_wb;
        int          e_mem;
        logic        e_we;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    function automatic logic [31:0] enc(input logic [2:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
        return {op, 3'b000, rs, rt, imm};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Fetch one instruction and follow it until the next fetch request or halt
    task automatic run_instr(input logic [31:0] instr, input int fw, input int mem_delay);
        int guard = 0;
        int post  = 0;
        r_cycles = 0; r_ctl_cnt = 0; r_mem = 0;
        r_reg1 = '0; r_reg2 = '0; r_alu = '0; r_imm = 0;
        r_rw = 0; r_rd = 0; r_we = 0; r_wb = '0;
        while (!imem_req && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        if (!imem_req) begin
            n_cmp++; n_err++;
            $display("FAIL fetch_req: imem_req got 0, expected 1 within 20 cycles");
            return;
        end
        r_cycles = 1;
        for (int w = 0; w < fw; w++) begin
            imem_ready = 1'b0;
            imem_rdata = {OP_HALT, 29'd0};
            @(negedge clock);
            r_cycles++;
        end
        imem_ready = 1'b1;
        imem_rdata = instr;
        @(negedge clock);
        imem_ready = 1'b0;
        imem_rdata = {OP_HALT, 29'd0};
        while (!imem_req && !halted && post < 60) begin
            post++;
            r_cycles++;
            if (post == 1) begin r_reg1 = reg1; r_reg2 = reg2; end
            if (post == 2) begin r_alu = alu_op; r_imm = alu_src_imm; end
            if (reg_write || reg_dest || wb_sel != 2'b00) begin
                r_ctl_cnt++; r_rw = reg_write; r_rd = reg_dest; r_wb = wb_sel;
            end
            if (dmem_req) begin
                r_mem++;
                r_we = r_we | dmem_we;
                dmem_ready = (r_mem > mem_delay);
            end else begin
                dmem_ready = 1'b0;
            end
            @(negedge clock);
        end
        dmem_ready = 1'b0;
        if (post >= 60) begin
            n_cmp++; n_err++;
            $display("FAIL instr_done: no fetch/halt within 60 cycles (got busy, expected done)");
        end
        r_pc     = pc;
        r_halted = halted;
    endtask

    task automatic set_pc(input logic [31:0] target);
        {flag_zero, flag_sign, flag_carry} = 3'b000;
        read1 = target;
        run_instr({OP_JR, 29'd0}, 0, 0);
    endtask

    // Halt must persist whatever the memories do, and only reset clears it
    task automatic check_stuck(input string name);
        logic bad = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = enc(OP_ALU, 5'd1, 5'd2, 16'd0);
        dmem_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (imem_req || !halted || dmem_req || reg_write) bad = 1'b1;
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        check({name, ".stuck"}, 32'(bad), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check({name, ".halted_clr"}, 32'(halted), 32'd0);
        check({name, ".pc_rst"}, pc, 32'h0);
        reset = 1'b1;
        @(negedge clock);
        check({name, ".refetch"}, 32'(imem_req), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        int guard;
        vecs[0]  = '{32'h0, enc(OP_ALU, 5'd3, 5'd4, 16'h0000), 32'hDEAD_0000, 3'b000, 0, 0, 4,
                     5'd3, 5'd4, ALU_ADD, 1'b0, 1'b1, 1'b0, WB_ALU, 0, 1'b0, 32'h4};
        vecs[1]  = '{32'h100, enc(OP_ALU, 5'd9, 5'd10, 16'h0006), 32'hDEAD_0000, 3'b000, 0, 0, 4,
                     5'd9, 5'd10, 5'd6, 1'b0, 1'b1, 1'b0, WB_ALU, 0, 1'b0, 32'h104};
        vecs[2]  = '{32'h200, enc(OP_ALUI, 5'd2, 5'd5, 16'h1234), 32'hDEAD_0000, 3'b000, 2, 0, 6,
                     5'd2, 5'd5, ALU_ADD, 1'b1, 1'b1, 1'b0, WB_ALU, 0, 1'b0, 32'h204};
        vecs[3]  = '{32'h40, enc(OP_LD, 5'd1, 5'd7, 16'h0008), 32'hDEAD_0000, 3'b000, 0, 3, 8,
                     5'd1, 5'd7, ALU_ADD, 1'b1, 1'b1, 1'b1, WB_MEM, 4, 1'b0, 32'h44};
        vecs[4]  = '{32'h80, enc(OP_ST, 5'd2, 5'd3, 16'h0010), 32'hDEAD_0000, 3'b000, 0, 0, 4,
                     5'd2, 5'd3, ALU_ADD, 1'b1, 1'b0, 1'b0, WB_ALU, 1, 1'b1, 32'h84};
        // Branch on zero, imm=-2
        vecs[5]  = '{32'h10, enc(OP_BR, 5'd0, 5'd0, 16'hFFC1), 32'hDEAD_0000, 3'b100, 0, 0, 3,
                     5'd0, 5'd0, ALU_ADD, 1'b0, 1'b0, 1'b0, WB_ALU, 0, 1'b0, 32'h0C};
        vecs[6]  = '{32'h10, enc(OP_BR, 5'd0, 5'd0, 16'hFFC1), 32'hDEAD_0000, 3'b000, 0, 0, 3,
                     5'd0, 5'd0, ALU_ADD, 1'b0, 1'b0, 1'b0, WB_ALU, 0, 1'b0, 32'h14};
        // Always, imm=+3
        vecs[7]  = '{32'h200, enc(OP_BR, 5'd0, 5'd0, 16'h0060), 32'hDEAD_0000, 3'b000, 0, 0, 3,
                     5'd0, 5'd0, ALU_ADD, 1'b0, 1'b0, 1'b0, WB_ALU, 0, 1'b0, 32'h210};
        // Condition 5 never branches even with all flags set
        vecs[8]  = '{32'h200, enc(OP_BR, 5'd0, 5'd0, 16'h0065), 32'hDEAD_0000, 3'b111, 0, 0, 3,
                     5'd0, 5'd0, ALU_ADD, 1'b0, 1'b0, 1'b0, WB_ALU, 0, 1'b0, 32'h204};
        // Sign, imm=-1
        vecs[9]  = '{32'h300, enc(OP_BR, 5'd0, 5'd0, 16'hFFE2), 32'hDEAD_0000, 3'b010, 0, 0, 3,
                     5'd0, 5'd0, ALU_ADD, 1'b0, 1'b0, 1'b0, WB_ALU, 0, 1'b0, 32'h300};
        // Carry clear, other flags set -> not taken
        vecs[10] = '{32'h300, enc(OP_BR, 5'd0, 5'd0, 16'h0063), 32'hDEAD_0000, 3'b110, 0, 0, 3,
                     5'd0, 5'd0, ALU_ADD, 1'b0, 1'b0, 1'b0, WB_ALU, 0, 1'b0, 32'h304};
        vecs[11] = '{32'h300, enc(OP_BR, 5'd0, 5'd0, 16'h0063), 32'hDEAD_0000, 3'b001, 0, 0, 3,
                     5'd0, 5'd0, ALU_ADD, 1'b0, 1'b0, 1'b0, WB_ALU, 0, 1'b0, 32'h310};
        // Branch-and-link, imm=4
        vecs[12] = '{32'h20, enc(OP_BAL, 5'd0, 5'd0, 16'h0004), 32'hDEAD_0000, 3'b000, 0, 0, 4,
                     5'd0, 5'd0, ALU_ADD, 1'b0, 1'b0, 1'b1, WB_PC4, 0, 1'b0, 32'h34};
        vecs[13] = '{32'h50, enc(OP_JR, 5'd0, 5'd0, 16'h0000), 32'h1234_5678, 3'b000, 0, 0, 3,
                     5'd0, 5'd0, ALU_ADD, 1'b0, 1'b0, 1'b0, WB_ALU, 0, 1'b0, 32'h1234_5678};
        // PC wraps past the top of the address space
        vecs[14] = '{32'hFFFF_FFFC, enc(OP_ALU, 5'd31, 5'd0, 16'h0003), 32'hDEAD_0000, 3'b000, 0, 0, 4,
                     5'd31, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0, WB_ALU, 0, 1'b0, 32'h0};

        imem_rdata = {OP_HALT, 29'd0};
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        read1      = 32'h0;
        {flag_zero, flag_sign, flag_carry} = 3'b000;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst.imem_req", 32'(imem_req), 32'd0);
        check("rst.pc", pc, 32'h0);
        check("rst.halted", 32'(halted), 32'd0);
        check("rst.dmem_req", 32'(dmem_req), 32'd0);
        check("rst.reg_write", 32'(reg_write), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            vec_t v;
            v = vecs[i];
            set_pc(v.start_pc);
            check($sformatf("v%0d.setpc", i), r_pc, v.start_pc);
            read1 = v.rd1;
            {flag_zero, flag_sign, flag_carry} = v.flags;
            run_instr(v.instr, v.fw, v.md);
            check($sformatf("v%0d.cycles", i), 32'(r_cycles), 32'(v.cyc));
            check($sformatf("v%0d.reg1", i), 32'(r_reg1), 32'(v.e_reg1));
            check($sformatf("v%0d.reg2", i), 32'(r_reg2), 32'(v.e_reg2));
            check($sformatf("v%0d.alu_op", i), 32'(r_alu), 32'(v.e_alu));
            check($sformatf("v%0d.alu_src_imm", i), 32'(r_imm), 32'(v.e_imm));
            check($sformatf("v%0d.wb_cycles", i), 32'(r_ctl_cnt),
                  (v.e_rw || v.e_rd || v.e_wb != 2'b00) ? 32'd1 : 32'd0);
            check($sformatf("v%0d.reg_write", i), 32'(r_rw), 32'(v.e_rw));
            check($sformatf("v%0d.reg_dest", i), 32'(r_rd), 32'(v.e_rd));
            check($sformatf("v%0d.wb_sel", i), 32'(r_wb), 32'(v.e_wb));
            check($sformatf("v%0d.mem_cycles", i), 32'(r_mem), 32'(v.e_mem));
            check($sformatf("v%0d.dmem_we", i), 32'(r_we), 32'(v.e_we));
            check($sformatf("v%0d.pc", i), r_pc, v.e_pc);
            check($sformatf("v%0d.halted", i), 32'(r_halted), 32'd0);
        end

        // Reset while a load is waiting in MEM
        set_pc(32'h40);
        guard = 0;
        while (!imem_req && guard < 20) begin @(negedge clock); guard++; end
        imem_ready = 1'b1;
        imem_rdata = enc(OP_LD, 5'd1, 5'd7, 16'h0008);
        @(negedge clock);
        imem_ready = 1'b0;
        imem_rdata = {OP_HALT, 29'd0};
        guard = 0;
        while (!dmem_req && guard < 10) begin @(negedge clock); guard++; end
        @(negedge clock);
        @(negedge clock);
        check("midmem.dmem_req", 32'(dmem_req), 32'd1);
        reset = 1'b0;
        @(negedge clock);
        check("midmem_rst.dmem_req", 32'(dmem_req), 32'd0);
        check("midmem_rst.pc", pc, 32'h0);
        check("midmem_rst.imem_req", 32'(imem_req), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        check("midmem_rst.refetch", 32'(imem_req), 32'd1);

        // Data memory never answers: halt after 16 MEM cycles
        run_instr(enc(OP_LD, 5'd1, 5'd7, 16'h0008), 0, 1000);
        check("timeout.mem_cycles", 32'(r_mem), 32'd16);
        check("timeout.cycles", 32'(r_cycles), 32'd19);
        check("timeout.halted", 32'(r_halted), 32'd1);
        check_stuck("timeout");

        // HALT opcode
        run_instr({OP_HALT, 29'd0}, 0, 0);
        check("halt.cycles", 32'(r_cycles), 32'd2);
        check("halt.halted", 32'(r_halted), 32'd1);
        check("halt.pc", r_pc, 32'h0);
        check("halt.reg_write", 32'(r_ctl_cnt), 32'd0);
        check_stuck("halt");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/kgp_control_fsm.md
Name: kgp_control_fsm

Overview:
Multicycle control unit for the KGP-RISC core. It sits directly upstream of the register file and sequences fetch, decode, execute, memory and writeback. It drives the register-file address and write controls (reg1, reg2, reg_write, reg_dest), the ALU and memory controls, and owns the program counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_WAIT_MAX, 16, max cycles waiting on dmem_ready before error halt

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
imem_rdata  input  32  instruction word, valid when imem_ready=1
imem_ready  input  1  instruction memory response
imem_req  output  1  instruction fetch request
pc  output  32  current PC, also the fetch address
dmem_ready  input  1  data memory completion
dmem_req  output  1  data access request
dmem_we  output  1  1=store, 0=load
read1  input  32  register-file port 1 data (jump-register target)
flag_zero, flag_sign, flag_carry  input  1 each  ALU flags from last EXEC
reg1  output  5  register-file address 1 = instr[25:21] (rs)
reg2  output  5  register-file address 2 = instr[20:16] (rt)
reg_write  output  1  register-file write control
reg_dest  output  1  register-file destination select
alu_op  output  5  ALU function = instr[4:0] for class 000, ADD otherwise
alu_src_imm  output  1  ALU operand B = sign-extended instr[15:0]
wb_sel  output  2  00 ALU, 01 memory, 10 PC+4
halted  output  1  sticky halt/error indicator

Behaviour:
- Reset (reset=0 at a clock edge, in any state): state<=FETCH, pc<=RESET_PC, IR<=0. All control outputs are 0, including halted. An access in flight is abandoned.
- Instruction register: IR loads imem_rdata in FETCH when imem_ready=1. reg1 and reg2 are decoded from IR, so they are stable from DECODE onward.
- Opcode field is IR[31:29]:
  - 000 ALU reg-reg: rs <= rs op rt.
  - 001 ALU immediate.
  - 010 LD: rt <= mem[rs+imm].
  - 011 ST: mem[rs+imm] <= rt.
  - 100 conditional branch; condition in IR[4:0]: 0 always, 1 zero, 2 sign, 3 carry, others never.
  - 101 branch-and-link.
  - 110 jump to read1.
  - 111 HALT.
- States:
  - FETCH: imem_req=1 held until imem_ready, then go to DECODE.
  - DECODE: 1 cycle. Opcode 111 goes to HALT; otherwise go to EXEC.
  - EXEC: 1 cycle. alu_src_imm=1 for opcodes 001, 010 and 011. Branch and jump opcodes update pc here and return to FETCH: taken branch pc<=pc+4+(sext(imm)<<2), not taken pc<=pc+4, jump pc<=read1. LD and ST go to MEM. ALU opcodes and branch-and-link go to WB.
  - MEM: dmem_req=1 and dmem_we=(op==011) held until dmem_ready. LD then goes to WB. ST does pc<=pc+4 and goes to FETCH. If MEM_WAIT_MAX cycles pass without dmem_ready, go to HALT.
  - WB: exactly one cycle, pc<=pc+4, then FETCH. Register-file controls:
    - ALU ops: reg_write=1, reg_dest=0 (writes rs), wb_sel=00.
    - LD: reg_write=1, reg_dest=1 (writes rt), wb_sel=01.
    - Branch-and-link: reg_write=0, reg_dest=1 (writes r31), wb_sel=10; branch target is loaded into pc instead of pc+4.
  - HALT: absorbing state, halted=1, all other outputs 0; exits only on reset.
- reg_write and reg_dest are 0 in every state except WB. The link encoding therefore can never fire spuriously.
- Latency with zero-wait memories:
  - ALU and link: 4 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles.
  - Branch and jump: 3 cycles.
- pc arithmetic is modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
- imem_rdata is ignored while imem_ready=0. dmem_ready outside MEM is ignored.

Decomposition:
- Shared package kgp_pkg holds:
  - Opcode constants OP_ALU..OP_HALT.
  - State enum.
  - wb_sel codes.
  - Branch condition codes.
  - ALU_ADD.
- Sub-module kgp_branch_unit: combinational, computes taken and target pc from IR, pc, flags and read1.

Test Plan:
1. ALU add: IR=000,rs=3,rt=4,func=ADD, imem_ready immediate -> reg_write=1 and reg_dest=0 for exactly one cycle, 4 cycles after the FETCH request; reg1=3; pc 0->4.
2. LD with dmem_ready delayed 3 cycles: IR=010,rs=1,rt=7,imm=8 -> dmem_req high for 4 cycles, dmem_we=0; then WB with reg_dest=1, reg2=7, wb_sel=01.
3. Branch on zero at pc=0x10, imm=-2: flag_zero=1 -> pc=0x0C after EXEC, reg_write stays 0 throughout. Repeat with flag_zero=0 -> pc=0x14.
4. Branch-and-link at pc=0x20, imm=4 -> WB has reg_write=0, reg_dest=1, wb_sel=10; next pc=0x34.
5. Reset mid-MEM: reset=0 while dmem_req=1 -> next cycle dmem_req=0, pc=RESET_PC, state FETCH. Also: dmem_ready never asserted -> halted=1 after 16 cycles in MEM.
6. HALT opcode -> halted=1 and imem_req=0 indefinitely, until reset=0 clears them.
